// File: rtl/fixed_to_float_pipe_if.sv
// Stream bundle for the fixed-point to float converter: a fixed-point sample
// flows in with its binary-point position, and a packed IEEE-754 single flows out.
interface fixed_to_float_pipe_if #(
   parameter int IN_WIDTH  = 32,
   parameter int POS_WIDTH = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [POS_WIDTH-1:0] fixpointpos;
   logic [IN_WIDTH-1:0]  targetnumber;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          result;

   // Upstream producer and downstream consumer side (drives samples, takes results).
   modport master (
      output in_valid, fixpointpos, targetnumber, out_ready,
      input  in_ready, out_valid, result
   );

   // The converter itself.
   modport slave (
      input  in_valid, fixpointpos, targetnumber, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 single converter: capture/magnitude,
// normalise, round/pack. One sample per cycle with a single global stall.
module fixed_to_float_pipe #(
   parameter int IN_WIDTH  = 32,
   parameter int POS_WIDTH = 5,
   parameter int SIGNED    = 1,
   parameter int ROUND_EN  = 1
) (
   input logic                 clk,
   input logic                 rst,
   fixed_to_float_pipe_if.slave bus
);
   localparam int LW = $clog2(IN_WIDTH);
   localparam int EW = IN_WIDTH + 24;

   // Handshake: a sample moves on an edge where valid & ready are both high.
   // Every stage advances together whenever the output slot is empty or being
   // taken; otherwise the whole pipe (bubbles included) holds.
   logic adv;

   logic                 s1_valid, s1_sign, s1_zero;
   logic [IN_WIDTH-1:0]  s1_mag;
   logic [POS_WIDTH-1:0] s1_pos;

   logic                 s2_valid, s2_sign, s2_zero, s2_guard, s2_sticky;
   logic [22:0]          s2_mant;
   logic [7:0]           s2_exp;

   logic                 s3_valid;
   logic [31:0]          s3_result;

   assign adv           = ~s3_valid | bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = s3_valid;
   assign bus.result    = s3_result;

   // S1 combinational: sign and magnitude (most negative value maps to 2^(N-1)).
   logic                neg;
   logic [IN_WIDTH-1:0] abs_val;
   assign neg     = (SIGNED != 0) && bus.targetnumber[IN_WIDTH-1];
   assign abs_val = neg ? (~bus.targetnumber + IN_WIDTH'(1)) : bus.targetnumber;

   // S2 combinational: leading-one position and left-justification.
   logic [LW-1:0] lead;
   logic [LW-1:0] shamt;
   logic [EW-1:0] ext;
   always_comb begin
      lead = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (s1_mag[i]) lead = LW'(i);
      end
      shamt = LW'(IN_WIDTH - 1) - lead;
      ext   = {s1_mag, 24'd0} << shamt;
   end

   // S3 combinational: round-to-nearest-even and pack; carry-out rolls into the exponent.
   logic        inc;
   logic [23:0] rnd;
   logic [7:0]  exp_f;
   logic [31:0] packed_val;
   always_comb begin
      inc        = (ROUND_EN != 0) && s2_guard && (s2_sticky || s2_mant[0]);
      rnd        = {1'b0, s2_mant} + {23'd0, inc};
      exp_f      = rnd[23] ? (s2_exp + 8'd1) : s2_exp;
      packed_val = s2_zero ? 32'd0 : {s2_sign, exp_f, rnd[22:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         s3_result <= 32'd0;
      end else if (adv) begin
         s1_valid  <= bus.in_valid;
         s1_sign   <= neg;
         s1_mag    <= abs_val;
         s1_pos    <= bus.fixpointpos;
         s1_zero   <= (bus.targetnumber == '0);

         s2_valid  <= s1_valid;
         s2_sign   <= s1_sign;
         s2_zero   <= s1_zero | ~ext[EW-1];
         s2_mant   <= ext[EW-2 -: 23];
         s2_guard  <= ext[IN_WIDTH-1];
         s2_sticky <= |ext[IN_WIDTH-2:0];
         s2_exp    <= 8'd127 + 8'(lead) - 8'(s1_pos);

         s3_valid  <= s2_valid;
         s3_result <= packed_val;
      end
   end
endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Directed bench for fixed_to_float_pipe: a rounding and a truncating 32-bit
// instance in lockstep, plus a 16-bit unsigned instance.
module tb_fixed_to_float_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fixed_to_float_pipe_if #(.IN_WIDTH(32), .POS_WIDTH(5)) ifa ();
   fixed_to_float_pipe_if #(.IN_WIDTH(32), .POS_WIDTH(5)) ift ();
   fixed_to_float_pipe_if #(.IN_WIDTH(16), .POS_WIDTH(4)) ifp ();

   assign ift.in_valid     = ifa.in_valid;
   assign ift.fixpointpos  = ifa.fixpointpos;
   assign ift.targetnumber = ifa.targetnumber;
   assign ift.out_ready    = ifa.out_ready;

   fixed_to_float_pipe #(.IN_WIDTH(32), .POS_WIDTH(5), .SIGNED(1), .ROUND_EN(1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   fixed_to_float_pipe #(.IN_WIDTH(32), .POS_WIDTH(5), .SIGNED(1), .ROUND_EN(0))
      dut_t (.clk(clk), .rst(rst), .bus(ift.slave));
   fixed_to_float_pipe #(.IN_WIDTH(16), .POS_WIDTH(4), .SIGNED(0), .ROUND_EN(1))
      dut_p (.clk(clk), .rst(rst), .bus(ifp.slave));

   // Push one sample through the 32-bit pair; lat counts edges from accept to out_valid (0 = timeout).
   task automatic convert(input logic [31:0] d, input logic [4:0] p,
                          output logic [31:0] ra, output logic [31:0] rt, output int lat);
      @(negedge clk);
      ifa.in_valid = 1'b1; ifa.targetnumber = d; ifa.fixpointpos = p; ifa.out_ready = 1'b1;
      @(posedge clk);
      #1 ifa.in_valid = 1'b0;
      ra = 32'hDEAD_BEEF; rt = 32'hDEAD_BEEF; lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ifa.out_valid) begin
            ra = ifa.result; rt = ift.result; lat = n;
            break;
         end
      end
   endtask

   task automatic convert_p(input logic [15:0] d, input logic [3:0] p,
                            output logic [31:0] r, output int lat);
      @(negedge clk);
      ifp.in_valid = 1'b1; ifp.targetnumber = d; ifp.fixpointpos = p; ifp.out_ready = 1'b1;
      @(posedge clk);
      #1 ifp.in_valid = 1'b0;
      r = 32'hDEAD_BEEF; lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ifp.out_valid) begin
            r = ifp.result; lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0 || ifa.result !== 32'd0) begin
         failures++;
         $display("FAIL reset_a out_valid=%b result=%h required 0/00000000", ifa.out_valid, ifa.result);
      end
      checks++;
      if (ifp.out_valid !== 1'b0 || ifp.result !== 32'd0) begin
         failures++;
         $display("FAIL reset_p out_valid=%b result=%h required 0/00000000", ifp.out_valid, ifp.result);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ifa.in_ready !== 1'b1 || ift.in_ready !== 1'b1 || ifp.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready a=%b t=%b p=%b required 1", ifa.in_ready, ift.in_ready, ifp.in_ready);
      end
   endtask

   task automatic test_basic;
      logic [31:0] din [3];
      logic [4:0]  pin [3];
      logic [31:0] exp_r [3];
      logic [31:0] ra, rt;
      int lat;
      din = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003};
      pin = '{5'd0, 5'd0, 5'd1};
      exp_r = '{32'h3F80_0000, 32'hBF80_0000, 32'h3FC0_0000};
      for (int i = 0; i < 3; i++) begin
         convert(din[i], pin[i], ra, rt, lat);
         checks++;
         if (ra !== exp_r[i]) begin
            failures++;
            $display("FAIL basic_%0d result=%h required %h", i, ra, exp_r[i]);
         end
         checks++;
         if (lat !== 3) begin
            failures++;
            $display("FAIL basic_latency_%0d latency=%0d required 3", i, lat);
         end
      end
   endtask

   task automatic test_extremes;
      logic [31:0] din [3];
      logic [4:0]  pin [3];
      logic [31:0] exp_r [3];
      logic [31:0] ra, rt;
      int lat;
      din = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
      pin = '{5'd0, 5'd17, 5'd31};
      exp_r = '{32'hCF00_0000, 32'h0000_0000, 32'h3000_0000};
      for (int i = 0; i < 3; i++) begin
         convert(din[i], pin[i], ra, rt, lat);
         checks++;
         if (ra !== exp_r[i] || rt !== exp_r[i]) begin
            failures++;
            $display("FAIL extreme_%0d round=%h trunc=%h required %h", i, ra, rt, exp_r[i]);
         end
      end
   endtask

   task automatic test_rounding;
      logic [31:0] din [3];
      logic [31:0] exp_rn [3];
      logic [31:0] exp_tr [3];
      logic [31:0] ra, rt;
      int lat;
      din    = '{32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF};
      exp_rn = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000};
      exp_tr = '{32'h4B80_0000, 32'h4B80_0001, 32'h4EFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         convert(din[i], 5'd0, ra, rt, lat);
         checks++;
         if (ra !== exp_rn[i]) begin
            failures++;
            $display("FAIL round_rne_%0d result=%h required %h", i, ra, exp_rn[i]);
         end
         checks++;
         if (rt !== exp_tr[i]) begin
            failures++;
            $display("FAIL round_trunc_%0d result=%h required %h", i, rt, exp_tr[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_q[$];
      logic [31:0] vals [8];
      logic [31:0] prev_res;
      logic [31:0] want;
      logic prev_hold;
      int sent, got;
      vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
      sent = 0; got = 0; prev_hold = 1'b0; prev_res = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         ifa.out_ready = !(cyc >= 4 && cyc < 9);
         ifa.fixpointpos = 5'd0;
         ifa.targetnumber = 32'(sent + 1);
         ifa.in_valid = (sent < 8);
         #1;
         if (prev_hold) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.result !== prev_res) begin
               failures++;
               $display("FAIL stall_hold cyc=%0d out_valid=%b result=%h required 1/%h",
                        cyc, ifa.out_valid, ifa.result, prev_res);
            end
         end
         if (ifa.out_valid && !ifa.out_ready) begin
            checks++;
            if (ifa.in_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_in_ready cyc=%0d in_ready=%b required 0", cyc, ifa.in_ready);
            end
         end
         if (ifa.in_valid && ifa.in_ready) begin
            exp_q.push_back(vals[sent]);
            sent++;
         end
         if (ifa.out_valid && ifa.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra result=%h required no output", ifa.result);
            end else begin
               want = exp_q.pop_front();
               if (ifa.result !== want) begin
                  failures++;
                  $display("FAIL stream_%0d result=%h required %h", got, ifa.result, want);
               end
            end
            got++;
         end
         prev_hold = ifa.out_valid && !ifa.out_ready;
         prev_res  = ifa.result;
      end
      ifa.in_valid = 1'b0;
      ifa.out_ready = 1'b1;
      checks++;
      if (got !== 8 || sent !== 8) begin
         failures++;
         $display("FAIL stream_count delivered=%0d sent=%0d required 8/8", got, sent);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ifa.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_dup cyc=%0d out_valid=%b required 0", i, ifa.out_valid);
         end
      end
   endtask

   task automatic test_reset_flight;
      logic [31:0] ra, rt;
      int lat;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ifa.in_valid = 1'b1; ifa.targetnumber = 32'(i + 5); ifa.fixpointpos = 5'd0;
         ifa.out_ready = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      ifa.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (ifa.out_valid !== 1'b0 || ift.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flight_reset out_valid a=%b t=%b required 0", ifa.out_valid, ift.out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ifa.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flight_stale cyc=%0d out_valid=%b result=%h required 0", i, ifa.out_valid, ifa.result);
         end
      end
      convert(32'h0000_0003, 5'd1, ra, rt, lat);
      checks++;
      if (ra !== 32'h3FC0_0000 || lat !== 3) begin
         failures++;
         $display("FAIL flight_after result=%h latency=%0d required 3fc00000/3", ra, lat);
      end
   endtask

   task automatic test_param;
      logic [31:0] r;
      int lat;
      // 0xFFFF with 8 fraction bits is 255.99609375.
      convert_p(16'hFFFF, 4'd8, r, lat);
      checks++;
      if (r !== 32'h437F_FF00 || lat !== 3) begin
         failures++;
         $display("FAIL param_ffff result=%h latency=%0d required 437fff00/3", r, lat);
      end
      convert_p(16'h8000, 4'd15, r, lat);
      checks++;
      if (r !== 32'h3F80_0000 || lat !== 3) begin
         failures++;
         $display("FAIL param_8000 result=%h latency=%0d required 3f800000/3", r, lat);
      end
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
      ifa.targetnumber = '0; ifa.fixpointpos = '0;
      ifp.in_valid = 1'b0; ifp.out_ready = 1'b1;
      ifp.targetnumber = '0; ifp.fixpointpos = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_rounding();
      test_back_to_back();
      test_reset_flight();
      test_param();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
